// File: rtl/conv10_pkg.sv
// Shared types and frame constants for the conv10 output-buffer stage.
//   data_t      : signed buffer word / channel average
//   gap_state_e : state encoding of the global-average-pooling reader
//   CONV10_*    : default frame geometry (46 channels x 16 pixels)
package conv10_pkg;

    localparam int unsigned CONV10_WIDTH    = 16;
    localparam int unsigned CONV10_ADDR     = 10;
    localparam int unsigned CONV10_CH       = 46;
    localparam int unsigned CONV10_PIX      = 16;
    localparam int unsigned CONV10_PIX_LOG2 = 4;

    typedef logic signed [CONV10_WIDTH-1:0] data_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        LAST = 3'd2,
        OUT  = 3'd3,
        DONE = 3'd4
    } gap_state_e;

endpackage

// File: rtl/gap_accum.sv
// Signed per-channel accumulator with final averaging shift.
//   clk, rst : clock and synchronous active-high reset
//   clr_i    : clear the running sum (start of a channel)
//   add_i    : add din_i (sign-extended) to the running sum
//   fin_i    : register (sum + din_i) >>> SHIFT as the channel average
//   din_i    : buffer word
//   avg_o    : registered channel average, held until the next fin_i
module gap_accum
    import conv10_pkg::*;
#(
    parameter int unsigned WIDTH = CONV10_WIDTH,
    parameter int unsigned SHIFT = CONV10_PIX_LOG2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             add_i,
    input  logic             fin_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] avg_o
);

    // SHIFT guard bits hold 2**SHIFT full-scale words without overflow.
    localparam int unsigned AccW = WIDTH + SHIFT;

    logic signed [AccW-1:0] acc_q, acc_d;
    logic signed [AccW-1:0] sum;
    logic        [WIDTH-1:0] avg_q, avg_d;

    always_comb begin
        sum = acc_q + AccW'($signed(din_i));
    end

    always_comb begin
        acc_d = acc_q;
        avg_d = avg_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (add_i) begin
            acc_d = sum;
        end
        // Taking the upper WIDTH bits of the signed sum is the arithmetic
        // shift; it floors toward -inf and always fits in WIDTH.
        if (fin_i) begin
            avg_d = sum[AccW-1:SHIFT];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            avg_q <= '0;
        end else begin
            acc_q <= acc_d;
            avg_q <= avg_d;
        end
    end

    assign avg_o = avg_q;

endmodule

// File: rtl/conv10_gap_reader.sv
// Global-average-pooling reader for the conv10 output buffer.
// Walks the buffer channel by channel (address = ch*PIX + pix), sums PIX
// signed words per channel and streams one average per channel.
//   clk, rst   : clock and synchronous active-high reset
//   start      : one-cycle frame start, honoured only when idle
//   buf_addr   : buffer read address (held when buf_rd_en is low)
//   buf_rd_en  : buffer read enable, data returns one cycle later
//   buf_dout   : buffer read data
//   out_data   : signed channel average
//   out_valid  : out_data valid, held until out_ready
//   out_ready  : downstream accept
//   busy       : high whenever not idle
//   done       : one-cycle pulse after the last channel is accepted
module conv10_gap_reader
    import conv10_pkg::*;
#(
    parameter int unsigned WIDTH    = CONV10_WIDTH,
    parameter int unsigned ADDR     = CONV10_ADDR,
    parameter int unsigned CH       = CONV10_CH,
    parameter int unsigned PIX      = CONV10_PIX,
    parameter int unsigned PIX_LOG2 = CONV10_PIX_LOG2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [ADDR-1:0]  buf_addr,
    output logic             buf_rd_en,
    input  logic [WIDTH-1:0] buf_dout,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] StIdle = 3'(IDLE);
    localparam logic [2:0] StRead = 3'(READ);
    localparam logic [2:0] StLast = 3'(LAST);
    localparam logic [2:0] StOut  = 3'(OUT);
    localparam logic [2:0] StDone = 3'(DONE);

    localparam int unsigned ChW  = (CH > 1) ? $clog2(CH) : 1;
    localparam int unsigned PixW = (PIX_LOG2 > 0) ? PIX_LOG2 : 1;

    localparam logic [ChW-1:0]  ChLast  = ChW'(CH - 1);
    localparam logic [PixW-1:0] PixLast = PixW'(PIX - 1);

    logic [2:0]      state_q, state_d;
    logic [ChW-1:0]  ch_q, ch_d;
    logic [PixW-1:0] pix_q, pix_d;
    logic [ADDR-1:0] addr_q, addr_d;
    logic            rd_dly_q, rd_dly_d;

    logic acc_clr;
    logic acc_fin;

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        pix_d   = pix_q;
        addr_d  = addr_q;
        acc_clr = 1'b0;
        acc_fin = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRead;
                    ch_d    = '0;
                    pix_d   = '0;
                    addr_d  = '0;
                    acc_clr = 1'b1;
                end
            end
            StRead: begin
                pix_d = pix_q + PixW'(1);
                // Keep the final address of the channel on the bus while idle
                // on the buffer side; the next channel bumps it on accept.
                if (pix_q == PixLast) begin
                    state_d = StLast;
                end else begin
                    addr_d = addr_q + ADDR'(1);
                end
            end
            StLast: begin
                acc_fin = 1'b1;
                state_d = StOut;
            end
            StOut: begin
                if (out_ready) begin
                    acc_clr = 1'b1;
                    if (ch_q == ChLast) begin
                        state_d = StDone;
                    end else begin
                        state_d = StRead;
                        ch_d    = ch_q + ChW'(1);
                        pix_d   = '0;
                        addr_d  = addr_q + ADDR'(1);
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Buffer data lags the read enable by one cycle.
    always_comb begin
        rd_dly_d = (state_q == StRead);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            ch_q     <= '0;
            pix_q    <= '0;
            addr_q   <= '0;
            rd_dly_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            pix_q    <= pix_d;
            addr_q   <= addr_d;
            rd_dly_q <= rd_dly_d;
        end
    end

    gap_accum #(
        .WIDTH (WIDTH),
        .SHIFT (PIX_LOG2)
    ) u_gap_accum (
        .clk   (clk),
        .rst   (rst),
        .clr_i (acc_clr),
        .add_i (rd_dly_q),
        .fin_i (acc_fin),
        .din_i (buf_dout),
        .avg_o (out_data)
    );

    assign buf_addr  = addr_q;
    assign buf_rd_en = (state_q == StRead);
    assign out_valid = (state_q == StOut);
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);

endmodule

// File: tb/tb_conv10_gap_reader.sv
// Scoreboard bench for conv10_gap_reader: a behavioural buffer feeds the
// reader, per-channel floor averages are queued at frame start and popped on
// each output handshake; addresses, latency and control are checked as well.
module tb_conv10_gap_reader;

    localparam int W   = 16;
    localparam int A   = 10;
    localparam int CH  = 46;
    localparam int PIX = 16;
    localparam int PL  = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [A-1:0] buf_addr;
    logic         buf_rd_en;
    logic [W-1:0] buf_dout;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
    logic         done;

    logic [W-1:0] mem [0:(2**A)-1];
    logic [W-1:0] exp_q [$];

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int start_cyc = 0;
    int exp_addr = 0;
    int rd_cnt = 0;
    int acc_cnt = 0;
    int done_cnt = 0;
    int done_cyc = 0;

    conv10_gap_reader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .buf_addr  (buf_addr),
        .buf_rd_en (buf_rd_en),
        .buf_dout  (buf_dout),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Single-port buffer with registered read gated by its enable.
    always @(posedge clk) begin
        if (buf_rd_en) buf_dout <= mem[buf_addr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Monitor: address order, scoreboard pops, done pulses.
    always @(negedge clk) begin
        if (buf_rd_en) begin
            check_eq("addr", 32'(buf_addr), exp_addr);
            exp_addr++;
            rd_cnt++;
        end
        if (out_valid && out_ready) begin
            check_eq("sb_nonempty", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) check_eq("avg", 32'(out_data), 32'(exp_q.pop_front()));
            acc_cnt++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic start_frame();
        int s;
        exp_q.delete();
        for (int c = 0; c < CH; c++) begin
            s = 0;
            for (int p = 0; p < PIX; p++) s += int'($signed(mem[c*PIX + p]));
            exp_q.push_back(W'(s >>> PL));
        end
        exp_addr = 0;
        rd_cnt   = 0;
        acc_cnt  = 0;
        done_cnt = 0;
        start     = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int i;
        i = 0;
        while (done_cnt == 0 && i < limit) begin
            @(posedge clk); #1;
            i++;
        end
        check_eq("done_seen", done_cnt, 1);
    endtask

    task automatic wait_acc(input int n, input int limit);
        int i;
        i = 0;
        while (acc_cnt < n && i < limit) begin
            @(posedge clk); #1;
            i++;
        end
        check_eq("reach_ch", acc_cnt, n);
    endtask

    task automatic fill_random();
        for (int a = 0; a < 2**A; a++) mem[a] = W'($urandom);
    endtask

    initial begin
        logic [W-1:0] held;
        int i;
        rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_rd_en", buf_rd_en, 0);
        check_eq("rst_addr", 32'(buf_addr), 0);
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_data", 32'(out_data), 0);
        check_eq("rst_done", done, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Uniform positive frame.
        for (int a = 0; a < 2**A; a++) mem[a] = 16'h0010;
        start_frame();
        wait_done(2000);
        check_eq("done_latency", done_cyc - start_cyc, 829);
        check_eq("rd_count", rd_cnt, CH*PIX);
        check_eq("out_count", acc_cnt, CH);
        check_eq("sb_left", exp_q.size(), 0);
        check_eq("idle_after", busy, 0);

        // Signed floor, extremes, start while busy, backpressure on channel 3.
        fill_random();
        for (int p = 0; p < PIX; p++) begin
            mem[0*PIX + p] = (p == PIX-1) ? 16'hFFF1 : 16'h0000;
            mem[1*PIX + p] = (p == PIX-1) ? 16'h000F : 16'h0000;
            mem[5*PIX + p] = 16'h7FFF;
            mem[6*PIX + p] = 16'h8000;
            mem[7*PIX + p] = 16'hFFFF;
        end
        start_frame();
        wait_acc(2, 200);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_acc(3, 200);
        out_ready = 1'b0;
        i = 0;
        while (!out_valid && i < 100) begin
            @(posedge clk); #1;
            i++;
        end
        check_eq("bp_valid_rise", out_valid, 1);
        held = out_data;
        for (int k = 0; k < 5; k++) begin
            check_eq("bp_valid_held", out_valid, 1);
            check_eq("bp_data_stable", 32'(out_data), 32'(held));
            check_eq("bp_no_read", buf_rd_en, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("ch4_read_start", buf_rd_en, 1);
        check_eq("ch4_first_addr", 32'(buf_addr), 4*PIX);
        wait_done(2000);
        check_eq("out_count2", acc_cnt, CH);
        check_eq("rd_count2", rd_cnt, CH*PIX);
        check_eq("sb_left2", exp_q.size(), 0);

        // Reset during channel 10.
        fill_random();
        start_frame();
        wait_acc(10, 400);
        repeat (3) @(posedge clk);
        #1;
        check_eq("pre_rst_reading", buf_rd_en, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_rd_en", buf_rd_en, 0);
        check_eq("mid_rst_addr", 32'(buf_addr), 0);
        check_eq("mid_rst_valid", out_valid, 0);
        check_eq("mid_rst_data", 32'(out_data), 0);
        repeat (5) @(posedge clk);
        #1;
        check_eq("mid_rst_no_done", done_cnt, 0);
        check_eq("mid_rst_still_idle", busy, 0);

        // Restart after the abandoned frame.
        fill_random();
        start_frame();
        check_eq("restart_rd_en", buf_rd_en, 1);
        check_eq("restart_addr", 32'(buf_addr), 0);
        wait_done(2000);
        check_eq("done_latency4", done_cyc - start_cyc, 829);
        check_eq("out_count4", acc_cnt, CH);
        check_eq("sb_left4", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
